// File: rtl/time_pkg.sv
// ---------------------------------------------------------------------------
// time_pkg
// Shared definitions for the time-setting controller: the mode/state
// encoding seen on the mode output, and small helpers used to size the
// internal timers from the module parameters.
// ---------------------------------------------------------------------------
package time_pkg;

  // Controller state; the encoding is driven directly onto the mode port.
  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10
  } mode_e;

  // Bits needed to hold any value in 0..n (never less than one bit).
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_edge.sv
// ---------------------------------------------------------------------------
// key_edge
// Registers a debounced, clk-synchronous key level and flags its rising
// edge. The history register is preset to 1 on reset, so a key that is
// already held down when reset is released never reports a press.
//
// Ports
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   btn   in  key level
//   rise  out high while btn=1 and the registered previous level is 0
// ---------------------------------------------------------------------------
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic prev;

  // Previous key level, preset high so a held key is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Front-panel controller for a clock display. In RUN it divides clk down to
// a one-per-second add_sec_l pulse. btn_mode cycles RUN -> SET_HOUR ->
// SET_MIN -> RUN; btn_inc advances the field being set; btn_clr zeroes the
// time counters in any state. Key priority on simultaneous presses is
// clr > mode > inc, and losing presses are dropped.
//
// Build option
//   TIME_CTRL_AUTO_REPEAT_EN  when defined, holding btn_inc in a set state
//                             emits an extra add pulse after REPEAT_DLY
//                             cycles and then every REPEAT_PER cycles.
//
// Parameters
//   DIV         clk cycles per second tick
//   REPEAT_DLY  held cycles before auto-repeat starts
//   REPEAT_PER  cycles between auto-repeat pulses
//
// Ports
//   clk, rst_n                      clock / async active-low reset
//   btn_mode, btn_inc, btn_clr      debounced key levels
//   add_sec_l, add_min_l, add_hour_l one-cycle advance pulses
//   clear                           one-cycle clear pulse
//   mode[1:0]                       00 RUN, 01 SET_HOUR, 10 SET_MIN
//   blink                           blink enable for the field being set
// All outputs are registered.
// ---------------------------------------------------------------------------
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int DIV        = 50000000,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clr,
  output logic       add_sec_l,
  output logic       add_min_l,
  output logic       add_hour_l,
  output logic       clear,
  output logic [1:0] mode,
  output logic       blink
);

  // Blink half period; a DIV of 1 would otherwise give a zero-length phase.
  localparam int HALF_DIV = (DIV / 2 > 0) ? DIV / 2 : 1;
  // One width shared by all timers, large enough for every limit.
  localparam int CNT_W    = cnt_width(max3(DIV, REPEAT_DLY, REPEAT_PER));

  mode_e            state, state_nxt;
  logic             mode_rise, inc_rise, clr_rise;
  logic             mode_go, inc_go, set_state;
  logic             rpt_fire;
  logic [CNT_W-1:0] presc, presc_nxt;
  logic [CNT_W-1:0] half_cnt, half_nxt;
  logic             sec_nxt, min_nxt, hour_nxt, clr_nxt, blink_nxt;

  key_edge u_edge_mode (.clk(clk), .rst_n(rst_n), .btn(btn_mode), .rise(mode_rise));
  key_edge u_edge_inc  (.clk(clk), .rst_n(rst_n), .btn(btn_inc),  .rise(inc_rise));
  key_edge u_edge_clr  (.clk(clk), .rst_n(rst_n), .btn(btn_clr),  .rise(clr_rise));

  // Priority resolution: a clear press masks mode and inc, mode masks inc.
  assign mode_go   = mode_rise & ~clr_rise;
  assign inc_go    = inc_rise & ~clr_rise & ~mode_rise;
  assign set_state = (state != MODE_RUN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MODE_RUN;
    else        state <= state_nxt;
  end

  // Next-state logic: one step around the mode ring per accepted mode press.
  always_comb begin
    state_nxt = state;
    if (mode_go) begin
      case (state)
        MODE_RUN:      state_nxt = MODE_SET_HOUR;
        MODE_SET_HOUR: state_nxt = MODE_SET_MIN;
        default:       state_nxt = MODE_RUN;
      endcase
    end
  end

`ifdef TIME_CTRL_AUTO_REPEAT_EN
  logic             rpt_active, rpt_active_nxt;
  logic             rpt_periodic, rpt_periodic_nxt;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt, rpt_cnt_inc;

  assign rpt_cnt_inc = rpt_cnt + CNT_W'(1);

  // Auto-repeat tracker. Armed by an accepted inc press in a set state;
  // rpt_cnt counts held cycles during the initial delay, then cycles since
  // the last repeat. Any release, clear or mode press disarms it.
  always_comb begin
    rpt_fire         = 1'b0;
    rpt_active_nxt   = 1'b0;
    rpt_periodic_nxt = 1'b0;
    rpt_cnt_nxt      = '0;
    if (inc_go && set_state) begin
      rpt_active_nxt = 1'b1;
      rpt_cnt_nxt    = CNT_W'(1);
    end else if (rpt_active && btn_inc && set_state && !clr_rise && !mode_rise) begin
      rpt_active_nxt   = 1'b1;
      rpt_periodic_nxt = rpt_periodic;
      rpt_cnt_nxt      = rpt_cnt_inc;
      if (!rpt_periodic && rpt_cnt_inc == CNT_W'(REPEAT_DLY)) begin
        rpt_fire         = 1'b1;
        rpt_periodic_nxt = 1'b1;
        rpt_cnt_nxt      = '0;
      end else if (rpt_periodic && rpt_cnt_inc == CNT_W'(REPEAT_PER)) begin
        rpt_fire    = 1'b1;
        rpt_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_active   <= 1'b0;
      rpt_periodic <= 1'b0;
      rpt_cnt      <= '0;
    end else begin
      rpt_active   <= rpt_active_nxt;
      rpt_periodic <= rpt_periodic_nxt;
      rpt_cnt      <= rpt_cnt_nxt;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Output logic: next values for the registered pulses, prescaler and
  // blink generator.
  always_comb begin
    sec_nxt   = 1'b0;
    presc_nxt = '0;
    // Prescaler only runs while staying in RUN; a clear or a mode press
    // zeroes it, so no second tick can leak into a set state.
    if (!clr_rise && !mode_go && state == MODE_RUN) begin
      if (presc == CNT_W'(DIV - 1)) begin
        sec_nxt = 1'b1;
      end else begin
        presc_nxt = presc + CNT_W'(1);
      end
    end

    clr_nxt  = clr_rise;
    hour_nxt = (state == MODE_SET_HOUR) && (inc_go || rpt_fire);
    min_nxt  = (state == MODE_SET_MIN)  && (inc_go || rpt_fire);

    // Blink restarts high on every entry into a set state and then
    // toggles each half period; it is forced low in RUN.
    if (state_nxt == MODE_RUN) begin
      blink_nxt = 1'b0;
      half_nxt  = '0;
    end else if (state_nxt != state) begin
      blink_nxt = 1'b1;
      half_nxt  = '0;
    end else if (half_cnt == CNT_W'(HALF_DIV - 1)) begin
      blink_nxt = ~blink;
      half_nxt  = '0;
    end else begin
      blink_nxt = blink;
      half_nxt  = half_cnt + CNT_W'(1);
    end
  end

  // Output and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      half_cnt   <= '0;
      add_sec_l  <= 1'b0;
      add_min_l  <= 1'b0;
      add_hour_l <= 1'b0;
      clear      <= 1'b0;
      blink      <= 1'b0;
    end else begin
      presc      <= presc_nxt;
      half_cnt   <= half_nxt;
      add_sec_l  <= sec_nxt;
      add_min_l  <= min_nxt;
      add_hour_l <= hour_nxt;
      clear      <= clr_nxt;
      blink      <= blink_nxt;
    end
  end

  assign mode = state;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000000, clk cycles per second tick.
REQ-002 SHALL have parameter REPEAT_DLY, default 25000000, held-cycles before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_PER, default 10000000, cycles between auto-repeat pulses.
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port btn_mode  input  1  debounced, clk-synchronous mode key, level.
REQ-007 SHALL have port btn_inc  input  1  debounced, clk-synchronous increment key, level.
REQ-008 SHALL have port btn_clr  input  1  debounced, clk-synchronous clear key, level.
REQ-009 SHALL have port add_sec_l  output  1  one-cycle pulse advancing seconds counter.
REQ-010 SHALL have port add_min_l  output  1  one-cycle pulse advancing minutes counter.
REQ-011 SHALL have port add_hour_l  output  1  one-cycle pulse advancing hours counter.
REQ-012 SHALL have port clear  output  1  one-cycle pulse zeroing all time counters.
REQ-013 SHALL have port mode  output  2  current state: 00 RUN, 01 SET_HOUR, 10 SET_MIN.
REQ-014 SHALL have port blink  output  1  display blink enable for field being set.

Function
REQ-015 SHALL detect key presses as rising edges (btn=1, registered previous=0); all outputs registered, pulse high exactly in the cycle after the sampling edge.
REQ-016 SHALL implement FSM RUN -> SET_HOUR -> SET_MIN -> RUN, one transition per btn_mode rising edge.
REQ-017 SHALL, in RUN, count prescaler 0..DIV-1 and pulse add_sec_l one cycle on each wrap from DIV-1 to 0.
REQ-018 SHALL hold prescaler at 0 in SET_HOUR/SET_MIN; add_sec_l never asserts outside RUN; first add_sec_l after returning to RUN occurs DIV cycles after the transition.
REQ-019 SHALL pulse add_hour_l on btn_inc edge in SET_HOUR and add_min_l on btn_inc edge in SET_MIN; btn_inc ignored in RUN.
REQ-020 SHALL pulse clear on btn_clr edge in any state, zero prescaler same cycle, leave state unchanged.
REQ-021 SHALL give priority clr > mode > inc on simultaneous edges; losing edges are discarded, not queued.
REQ-022 SHALL drive blink 0 in RUN; in set states toggle blink every DIV/2 cycles using a separate half-period counter, starting at 1 on state entry.
REQ-023 SHALL never assert more than one of add_sec_l/add_min_l/add_hour_l in a cycle.

Reset
REQ-024 SHALL on rst_n low set state RUN, mode 00, all pulses 0, blink 0, counters 0, edge-detector previous registers to 1 (a key held through reset generates no edge).
REQ-025 SHALL, on reset mid-operation, abort any auto-repeat or pending pulse with no output glitch after release.

Configuration
REQ-026 SHALL, with TIME_CTRL_AUTO_REPEAT_EN defined, while btn_inc held in a set state, emit an extra add pulse after REPEAT_DLY cycles then every REPEAT_PER cycles until release or state change.
REQ-027 SHALL, without TIME_CTRL_AUTO_REPEAT_EN, emit exactly one add pulse per btn_inc press; REPEAT_* parameters unused.

Structure
REQ-028 SHALL place mode encodings (RUN/SET_HOUR/SET_MIN) and state typedef in shared package time_pkg.
REQ-029 SHALL instantiate three copies of sub-module key_edge (register plus rising-edge pulse, preset-to-1 on reset).

Verification
REQ-030 SHALL verify DIV=10, RUN for 35 cycles -> add_sec_l pulses at cycles 10, 20, 30 only.
REQ-031 SHALL verify mode pressed three times -> mode 01, 10, 00; add_sec_l silent while mode!=00.
REQ-032 SHALL verify SET_HOUR, three btn_inc presses -> exactly three add_hour_l pulses, zero add_min_l.
REQ-033 SHALL verify btn_clr and btn_mode edges same cycle in SET_MIN -> clear pulse, mode stays 10.
REQ-034 SHALL verify btn_inc held from reset release -> no pulse; with macro, REPEAT_DLY=20, REPEAT_PER=5, hold 32 cycles in SET_MIN -> add_min_l pulses at hold cycles 1, 20, 25, 30.
REQ-035 SHALL verify rst_n asserted during auto-repeat -> all outputs 0 immediately, mode 00.
